// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, synchronous-read request tracking,
// a one-entry hold buffer for data returning during a stall, and the IF/ID register.
module fetch_unit #(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          if_id_valid,
  output logic [IW-1:0] if_id_instr,
  output logic [AW-1:0] if_id_pc,
  output logic [AW-1:0] if_id_pc_plus1
);

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t          state, state_next;
  logic [AW-1:0]   pc, req_pc, hold_pc;
  logic            req_valid;
  logic [IW-1:0]   hold_instr;
  logic            load_fetch, load_hold, load_held;

  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and IF/ID / hold-buffer load selects; redirect wins over stall
  always_comb begin
    state_next = state;
    load_fetch = 1'b0;
    load_hold  = 1'b0;
    load_held  = 1'b0;
    if (redirect) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            load_fetch = 1'b1;
          end else if (req_valid) begin
            load_hold  = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
        end
        HOLD: begin
          if (!stall) begin
            load_held  = 1'b1;
            state_next = RUN;
          end else begin
            state_next = HOLD;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // PC and request tag: the tag names the address whose data appears on imem_data now
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= {AW{1'b0}};
      req_valid <= 1'b0;
      req_pc    <= {AW{1'b0}};
    end else if (redirect) begin
      pc        <= redirect_target;
      req_valid <= 1'b0;
    end else if (stall) begin
      req_valid <= 1'b0;
    end else begin
      pc        <= pc + ONE;
      req_valid <= 1'b1;
      req_pc    <= pc;
    end
  end

  // Hold buffer catches the returning instruction that decode could not take
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      hold_instr <= {IW{1'b0}};
      hold_pc    <= {AW{1'b0}};
    end else if (load_hold) begin
      hold_instr <= imem_data;
      hold_pc    <= req_pc;
    end else begin
      hold_instr <= hold_instr;
      hold_pc    <= hold_pc;
    end
  end

  // IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= {IW{1'b0}};
      if_id_pc       <= {AW{1'b0}};
      if_id_pc_plus1 <= ONE;
    end else if (redirect) begin
      if_id_valid    <= 1'b0;
    end else if (load_fetch) begin
      if_id_valid    <= req_valid;
      if_id_instr    <= imem_data;
      if_id_pc       <= req_pc;
      if_id_pc_plus1 <= req_pc + ONE;
    end else if (load_held) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= hold_instr;
      if_id_pc       <= hold_pc;
      if_id_pc_plus1 <= hold_pc + ONE;
    end else begin
      if_id_valid    <= if_id_valid;
    end
  end

endmodule
